// File: rtl/ysyx_23060075_axil_sram.sv
// ysyx_23060075_axil_sram: AXI4-Lite word SRAM with byte strobes, fixed per-channel latency and SLVERR decode.
// Define YSYX_23060075_SRAM_RAND_LAT_EN (simulation only) to add 0..3 random cycles to each transaction's latency.
module ysyx_23060075_axil_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready
);
  localparam int SB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SB);
  localparam int CW = 8;
  localparam logic [CW-1:0] ONE = 1;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  r_state_t                rstate;
  w_state_t                wstate;
  logic [CW-1:0]           rcnt, wcnt;
  logic [ADDR_WIDTH-1:0]   raddr_q, waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [SB-1:0]           wstrb_q;
  logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];
  logic                    aw_hs, w_hs, werr, w_commit;
  function automatic logic bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] o;
    o = a - BASE_ADDR;
    return (a < BASE_ADDR) || ((o >> (OFF + DEPTH_LOG2)) != '0) || (a[OFF-1:0] != '0);
  endfunction
  function automatic logic [DEPTH_LOG2-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> OFF);
  endfunction
`ifdef YSYX_23060075_SRAM_RAND_LAT_EN
  function automatic logic [CW-1:0] lat(input int b);
    return CW'(b) + CW'({$random} % 4);
  endfunction
`else
  function automatic logic [CW-1:0] lat(input int b);
    return CW'(b);
  endfunction
`endif
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs = axi_wvalid && axi_wready;
  assign werr = bad(waddr_q);
  assign w_commit = (wstate == W_WAIT) && (wcnt == ONE) && !werr;
  // Memory is never reset; a reset during W_WAIT forces W_IDLE so nothing commits.
  always_ff @(posedge clk)
    if (w_commit)
      for (int b = 0; b < SB; b++)
        if (wstrb_q[b]) mem[idx(waddr_q)][b*8 +: 8] <= wdata_q[b*8 +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rstate      <= R_IDLE;
      rcnt        <= '0;
      raddr_q     <= '0;
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: if (axi_arvalid && axi_arready) begin
          raddr_q     <= axi_araddr;
          rcnt        <= lat(RD_LATENCY);
          axi_arready <= 1'b0;
          rstate      <= R_WAIT;
        end
        // Sampling on the same edge as a write commit returns the old word.
        R_WAIT: if (rcnt == ONE) begin
          axi_rdata  <= bad(raddr_q) ? '0 : mem[idx(raddr_q)];
          axi_rresp  <= bad(raddr_q) ? 2'b10 : 2'b00;
          axi_rvalid <= 1'b1;
          rcnt       <= '0;
          rstate     <= R_RESP;
        end else rcnt <= rcnt - ONE;
        R_RESP: if (axi_rready) begin
          axi_rvalid  <= 1'b0;
          axi_arready <= 1'b1;
          rstate      <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wstate      <= W_IDLE;
      wcnt        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
    end else begin
      case (wstate)
        // A dropped ready marks that half of the request as already captured.
        W_IDLE: begin
          if (aw_hs) begin
            waddr_q     <= axi_awaddr;
            axi_awready <= 1'b0;
          end
          if (w_hs) begin
            wdata_q    <= axi_wdata;
            wstrb_q    <= axi_wstrb;
            axi_wready <= 1'b0;
          end
          if ((!axi_awready || aw_hs) && (!axi_wready || w_hs)) begin
            wcnt   <= lat(WR_LATENCY);
            wstate <= W_WAIT;
          end
        end
        W_WAIT: if (wcnt == ONE) begin
          axi_bresp  <= werr ? 2'b10 : 2'b00;
          axi_bvalid <= 1'b1;
          wcnt       <= '0;
          wstate     <= W_RESP;
        end else wcnt <= wcnt - ONE;
        W_RESP: if (axi_bready) begin
          axi_bvalid  <= 1'b0;
          axi_awready <= 1'b1;
          axi_wready  <= 1'b1;
          wstate      <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
endmodule

// File: doc/ysyx_23060075_axil_sram.md
Name: ysyx_23060075_axil_sram

Overview:
Parametrised AXI4-Lite slave holding a synthesizable word-organised memory array. It is the next-generation on-chip SRAM behind the core's LSU/IFU arbiter. Compared with the previous generation it adds:
- configurable width, depth and base address;
- a fixed, parametrised per-channel latency;
- byte-strobe writes;
- SLVERR for out-of-range or misaligned accesses.

Read and write channels operate independently and concurrently.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; must be 32 or 64
- DEPTH_LOG2, 8, log2 of word count (default 256 words)
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- RD_LATENCY, 1, cycles from AR handshake to rvalid; must be >= 1
- WR_LATENCY, 1, cycles from the last of AW/W handshake to bvalid; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- axi_araddr  in  ADDR_WIDTH  read address
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_rdata  out  DATA_WIDTH  read data
- axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_awaddr  in  ADDR_WIDTH  write address
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_wdata  in  DATA_WIDTH  write data
- axi_wstrb  in  DATA_WIDTH/8  byte strobes
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - arready = awready = wready = 1.
  - rvalid = bvalid = 0; rdata = 0; rresp = bresp = 00.
  - Both FSMs return to idle; latency counters = 0.
  - Memory contents are not reset. In-flight transactions are dropped; no write commits.
- Address decode:
  - Index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - An access is an error if addr < BASE_ADDR, if addr >= BASE_ADDR + 2^DEPTH_LOG2 * DATA_WIDTH/8, or if the low log2(DATA_WIDTH/8) bits are non-zero.
- Read FSM, states R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready = 1. On arvalid && arready, latch the address and load counter = RD_LATENCY; go to R_WAIT; arready drops on the next cycle.
  - R_WAIT: counter decrements each cycle. When it reaches 1, at that edge: rdata = mem[index] (0 on error), rresp = 00 or 10, rvalid = 1; go to R_RESP. Net result: rvalid rises exactly RD_LATENCY cycles after the AR handshake edge.
  - R_RESP: rdata, rresp and rvalid are held stable until rready. On rvalid && rready, rvalid = 0, arready = 1, state = R_IDLE. The next AR can be accepted one cycle after the R handshake; there are no overlapping reads.
- Write FSM, states W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: AW and W are captured independently. awready drops after the AW handshake; wready drops after the W handshake. They may arrive in the same cycle or in either order.
  - When both are captured, load counter = WR_LATENCY and go to W_WAIT.
  - W_WAIT: at the edge where the counter reaches 1:
    - If no error: for each byte b with wstrb[b] = 1, mem[index].byte[b] = wdata.byte[b].
    - bresp = 00, or 10 on error (memory unchanged on error).
    - bvalid = 1; go to W_RESP.
  - W_RESP: bvalid and bresp are held until bready. On the handshake: bvalid = 0, awready = wready = 1, state = W_IDLE.
  - wstrb = 0 gives OKAY with no modification.
- Read/write collision: if the read sample and the write commit hit the same word on the same edge, the read returns the pre-write (old) data.
- rvalid/bvalid never drop without a handshake. Ready inputs held low indefinitely stall the channel with outputs stable.

Optional Feature:
- Macro: YSYX_23060075_SRAM_RAND_LAT_EN (simulation-only stress mode).
- Defined: each transaction's latency = base latency + ({$random} % 4), i.e. 0..3 extra cycles drawn at the AR or (AW+W) capture. All handshake, ordering and collision rules are unchanged.
- Undefined: latency is exactly RD_LATENCY / WR_LATENCY, and the block is fully synthesizable.

Test Plan:
- Defaults. Write 0xDEADBEEF to 0x8000_0010 with wstrb 0xF, AW and W in the same cycle, bready = 1 -> bvalid 1 cycle later, bresp 00. Then read 0x8000_0010 -> rvalid 1 cycle after AR, rdata 0xDEADBEEF, rresp 00.
- Byte strobe: mem[4] = 0x11223344; write 0xAABBCCDD with wstrb 0b0101 -> read back 0x11BB33DD.
- W sent 3 cycles before AW -> wready low after the W handshake; bvalid 1 cycle after AW accepted; awready and wready return to 1 the cycle after the B handshake.
- Error cases:
  - Read 0x8000_0400 -> rresp 10, rdata 0.
  - Write 0x8000_0002 -> bresp 10, target word unchanged.
  - Read 0x7FFF_FFFC -> rresp 10.
- RD_LATENCY = 4: rvalid rises exactly 4 cycles after the AR handshake. Hold rready low for 5 cycles -> rdata/rvalid stable, arready stays 0 until 1 cycle after the handshake.
- Assert rst during W_WAIT -> all outputs take reset values immediately, the target word keeps its old value, and a subsequent write completes normally.
